// File: rtl/line_fill_burst_adapter_pkg.sv
// Types and default geometry shared by the instruction-cache fill path.
package icache_pkg;
    typedef enum logic [1:0] {IDLE, REQ, FILL} fill_state_t;

    localparam int I_BURST  = 16;
    localparam int I_DATA_W = 32;
    localparam int I_LINE_W = 512;
    localparam int I_OFS_W  = 6;
endpackage

// File: rtl/line_fill_burst_adapter_if.sv
// Cache miss port (cache is master) and Avalon-MM burst read port (adapter is master).
interface cache_fill_if #(parameter int LINE_W = icache_pkg::I_LINE_W);
    logic [31:0]       c_address;
    logic              c_read;
    logic [4:0]        c_burstcount;
    logic              c_wait;
    logic [LINE_W-1:0] c_linedata;

    modport master (output c_address, c_read, c_burstcount, input c_wait, c_linedata);
    modport slave  (input c_address, c_read, c_burstcount, output c_wait, c_linedata);
endinterface

interface avalon_burst_if #(parameter int DATA_W = icache_pkg::I_DATA_W);
    logic [31:0]       m_address;
    logic              m_read;
    logic [4:0]        m_burstcount;
    logic              m_waitrequest;
    logic [DATA_W-1:0] m_readdata;
    logic              m_readdatavalid;

    modport master (output m_address, m_read, m_burstcount,
                    input m_waitrequest, m_readdata, m_readdatavalid);
    modport slave  (input m_address, m_read, m_burstcount,
                    output m_waitrequest, m_readdata, m_readdatavalid);
endinterface

// File: rtl/line_fill_burst_adapter.sv
// Turns one cache line request into a single Avalon burst read and packs the
// returned beats into a full line; c_wait covers the whole fill.
module line_fill_burst_adapter
    import icache_pkg::*;
#(
    parameter int BURST  = I_BURST,
    parameter int DATA_W = I_DATA_W,
    parameter int LINE_W = BURST * DATA_W,
    parameter int OFS_W  = $clog2(LINE_W / 8)
) (
    input  logic          clk,
    input  logic          reset,
    cache_fill_if.slave   c,
    avalon_burst_if.master m,
    output logic [31:0]   fill_count
);
    localparam int BEAT_W = $clog2(BURST);
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFS_W) - 32'd1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);

    fill_state_t       state;
    logic [BEAT_W-1:0] beat;
    logic              c_wait_q;
    logic              m_read_q;
    logic [31:0]       m_address_q;
    logic [LINE_W-1:0] line_q;

    assign c.c_wait       = c_wait_q;
    assign c.c_linedata   = line_q;
    assign m.m_read       = m_read_q;
    assign m.m_address    = m_address_q;
    assign m.m_burstcount = 5'(BURST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            beat        <= '0;
            c_wait_q    <= 1'b0;
            m_read_q    <= 1'b0;
            m_address_q <= '0;
            line_q      <= '0;
            fill_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Requests with the wrong burst length are silently dropped.
                    if (c.c_read && c.c_burstcount == 5'(BURST)) begin
                        m_address_q <= c.c_address & ADDR_MASK;
                        m_read_q    <= 1'b1;
                        c_wait_q    <= 1'b1;
                        beat        <= '0;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (!m.m_waitrequest) begin
                        m_read_q <= 1'b0;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (m.m_readdatavalid) begin
                        line_q[int'(beat) * DATA_W +: DATA_W] <= m.m_readdata;
                        beat <= beat + BEAT_W'(1);
                        if (beat == LAST_BEAT) begin
                            c_wait_q   <= 1'b0;
                            fill_count <= fill_count + 32'd1;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_fill_burst_adapter.sv
// Scoreboarded bench: expected lines are queued at request time, popped when c_wait falls.
module tb_line_fill_burst_adapter;
    import icache_pkg::*;

    logic clk;
    logic reset;
    logic [31:0] fill_count;

    cache_fill_if   #(.LINE_W(I_LINE_W)) cif ();
    avalon_burst_if #(.DATA_W(I_DATA_W)) mif ();

    line_fill_burst_adapter dut (
        .clk        (clk),
        .reset      (reset),
        .c          (cif.slave),
        .m          (mif.master),
        .fill_count (fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_fills = 0;
    logic [I_LINE_W-1:0] exp_q[$];
    logic [I_LINE_W-1:0] last_line = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cif.c_read = 1'b0; cif.c_address = '0; cif.c_burstcount = 5'd16;
        mif.m_waitrequest = 1'b0; mif.m_readdata = '0; mif.m_readdatavalid = 1'b0;
        repeat (3) step();
        checks++;
        if (cif.c_wait !== 1'b0 || mif.m_read !== 1'b0 || mif.m_address !== 32'd0 ||
            cif.c_linedata !== '0 || fill_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: c_wait=%b m_read=%b m_address=%h fill_count=%0d required all zero",
                     cif.c_wait, mif.m_read, mif.m_address, fill_count);
        end
        checks++;
        if (mif.m_burstcount !== 5'd16) begin
            errors++;
            $display("FAIL burstcount_const: got %0d required 16", mif.m_burstcount);
        end
        reset = 1'b0;
        exp_fills = 0;
        last_line = '0;
        step();
    endtask

    // One fill: optional command stall, gapped beats, busy c_read during FILL,
    // and reset injected once abort_at beats have been accepted.
    task automatic run_fill(input logic [31:0] addr, input int stall, input bit gap,
                            input bit busy, input int abort_at, input logic [31:0] base,
                            input string nm);
        logic [I_LINE_W-1:0] exp_line;
        logic [I_LINE_W-1:0] got_line;
        logic [31:0] exp_addr;
        int i;
        int cyc;
        bit aborted;
        exp_addr = {addr[31:6], 6'd0};
        for (int k = 0; k < 16; k++) exp_line[k*32 +: 32] = base + 32'(k);
        if (abort_at < 0) exp_q.push_back(exp_line);

        cif.c_read = 1'b1; cif.c_address = addr; cif.c_burstcount = 5'd16;
        mif.m_waitrequest = (stall > 0);
        step();
        cif.c_read = 1'b0;
        checks++;
        if (cif.c_wait !== 1'b1 || mif.m_address !== exp_addr) begin
            errors++;
            $display("FAIL %s_request: c_wait=%b m_address=%h required 1 / %h", nm, cif.c_wait, mif.m_address, exp_addr);
        end
        for (int k = 0; k < stall; k++) begin
            checks++;
            if (mif.m_read !== 1'b1 || mif.m_address !== exp_addr) begin
                errors++;
                $display("FAIL %s_stall_hold: m_read=%b m_address=%h required 1 / %h", nm, mif.m_read, mif.m_address, exp_addr);
            end
            step();
        end
        mif.m_waitrequest = 1'b0;
        checks++;
        if (mif.m_read !== 1'b1) begin
            errors++;
            $display("FAIL %s_read_high: m_read=%b required 1", nm, mif.m_read);
        end
        step();
        checks++;
        if (mif.m_read !== 1'b0) begin
            errors++;
            $display("FAIL %s_read_drop: m_read=%b required 0", nm, mif.m_read);
        end

        i = 0; cyc = 0; aborted = 1'b0;
        while (i < 16 && cyc < 64) begin
            if (abort_at >= 0 && i == abort_at) begin
                reset = 1'b1;
                #1;
                exp_fills = 0;
                last_line = '0;
                checks++;
                if (cif.c_linedata !== '0 || cif.c_wait !== 1'b0 || mif.m_read !== 1'b0 || fill_count !== 32'd0) begin
                    errors++;
                    $display("FAIL %s_abort: c_wait=%b m_read=%b fill_count=%0d line_nonzero=%b required all zero",
                             nm, cif.c_wait, mif.m_read, fill_count, |cif.c_linedata);
                end
                aborted = 1'b1;
                break;
            end
            checks++;
            if (cif.c_wait !== 1'b1 || mif.m_read !== 1'b0) begin
                errors++;
                $display("FAIL %s_inflight: beat=%0d c_wait=%b m_read=%b required 1 / 0", nm, i, cif.c_wait, mif.m_read);
            end
            if (busy) begin
                cif.c_read = 1'b1; cif.c_address = 32'h9999_0040;
            end
            if (gap && cyc[0]) begin
                mif.m_readdatavalid = 1'b0;
                mif.m_readdata = 32'hBAD0_0000;
            end else begin
                mif.m_readdatavalid = 1'b1;
                mif.m_readdata = base + 32'(i);
                i++;
            end
            cyc++;
            step();
        end
        mif.m_readdatavalid = 1'b0;
        cif.c_read = 1'b0;
        if (aborted) begin
            step();
            reset = 1'b0;
            step();
            return;
        end
        if (i < 16) begin
            errors++;
            $display("FAIL %s_timeout: only %0d beats driven", nm, i);
            return;
        end
        exp_fills++;
        checks++;
        if (cif.c_wait !== 1'b0) begin
            errors++;
            $display("FAIL %s_wait_fall: c_wait=%b required 0", nm, cif.c_wait);
        end
        got_line = cif.c_linedata;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard_empty", nm);
        end else begin
            exp_line = exp_q.pop_front();
            checks++;
            if (got_line !== exp_line) begin
                errors++;
                for (int k = 0; k < 16; k++)
                    if (got_line[k*32 +: 32] !== exp_line[k*32 +: 32])
                        $display("FAIL %s_line word %0d: got %h required %h", nm, k,
                                 got_line[k*32 +: 32], exp_line[k*32 +: 32]);
            end
            last_line = exp_line;
        end
        checks++;
        if (fill_count !== 32'(exp_fills)) begin
            errors++;
            $display("FAIL %s_fill_count: got %0d required %0d", nm, fill_count, exp_fills);
        end
        // Busy requests must not leave a queued fill behind.
        step();
        checks++;
        if (mif.m_read !== 1'b0 || cif.c_wait !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_after: m_read=%b c_wait=%b required 0 / 0", nm, mif.m_read, cif.c_wait);
        end
    endtask

    task automatic test_stray_data();
        for (int k = 0; k < 3; k++) begin
            mif.m_readdatavalid = 1'b1;
            mif.m_readdata = 32'hDEAD_0000 + 32'(k);
            step();
        end
        mif.m_readdatavalid = 1'b0;
        checks++;
        if (cif.c_linedata !== last_line || cif.c_wait !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle: line changed or c_wait=%b", cif.c_wait);
        end
        run_fill(32'h0000_2000, 0, 1'b0, 1'b0, 8, 32'hC000_0000, "abort");
        for (int k = 0; k < 4; k++) begin
            mif.m_readdatavalid = 1'b1;
            mif.m_readdata = 32'hFEED_0000 + 32'(k);
            step();
        end
        mif.m_readdatavalid = 1'b0;
        checks++;
        if (cif.c_linedata !== '0 || cif.c_wait !== 1'b0) begin
            errors++;
            $display("FAIL stray_after_reset: c_wait=%b line_nonzero=%b required 0 / 0", cif.c_wait, |cif.c_linedata);
        end
        run_fill(32'h0000_3FC4, 0, 1'b0, 1'b0, -1, 32'hD000_0000, "post_reset");
    endtask

    task automatic test_bad_length();
        cif.c_read = 1'b1; cif.c_address = 32'h0000_5000; cif.c_burstcount = 5'd8;
        step();
        cif.c_read = 1'b0; cif.c_burstcount = 5'd16;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mif.m_read !== 1'b0 || cif.c_wait !== 1'b0) begin
                errors++;
                $display("FAIL bad_length: cycle %0d m_read=%b c_wait=%b required 0 / 0", k, mif.m_read, cif.c_wait);
            end
            step();
        end
        checks++;
        if (cif.c_linedata !== last_line || fill_count !== 32'(exp_fills)) begin
            errors++;
            $display("FAIL bad_length_state: fill_count=%0d required %0d or line changed", fill_count, exp_fills);
        end
    endtask

    initial begin
        test_reset();
        run_fill(32'h0000_1234, 0, 1'b0, 1'b0, -1, 32'hA000_0000, "basic");
        run_fill(32'h8000_0FFF, 5, 1'b0, 1'b0, -1, 32'hB000_0000, "stall");
        run_fill(32'h0001_0040, 0, 1'b1, 1'b0, -1, 32'h1234_5600, "gapped");
        test_stray_data();
        run_fill(32'h0000_7780, 2, 1'b1, 1'b1, -1, 32'hE000_0010, "busy");
        test_bad_length();
        run_fill(32'hFFFF_FFFF, 1, 1'b0, 1'b0, -1, 32'h5A5A_0000, "back_to_back");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
